// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared FSM state encoding and default counter geometry
package mod_counter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int DEF_MOD   = 12;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_RUN_W = 4;
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: mod-MOD up-counter datapath with sync clear, enable and async clr
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int MOD   = DEF_MOD,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sclr,
  output logic [WIDTH-1:0] q,
  output logic             tc
);
  assign tc = q == WIDTH'(MOD - 1);
  always_ff @(posedge clk or posedge clr)
    if (clr) q <= '0;
    else if (sclr) q <= '0;
    else if (en) q <= tc ? '0 : q + 1'b1;
endmodule

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: start/pause/abort run controller for a mod-N counter (WRAP_COUNT_EN makes wrap_cnt live, else tied to 0)
module mod_counter_ctrl
  import mod_counter_pkg::*;
#(
  parameter int MOD   = DEF_MOD,
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUN_W = DEF_RUN_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [RUN_W-1:0] periods,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [RUN_W-1:0] wrap_cnt
);
  if (MOD > 2**WIDTH || MOD < 2) begin : g_bad_mod
    $error("mod_counter_ctrl: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  state_t state, state_n;
  logic [RUN_W-1:0] periods_q, pcnt;
  logic en, sclr, cnt_tc, ld, last;
  mod_n_counter #(.MOD(MOD), .WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .sclr (sclr),
    .q    (count),
    .tc   (cnt_tc)
  );
  assign ld   = state == ST_IDLE && start && !abort;
  assign last = periods_q != '0 && pcnt + RUN_W'(1) == periods_q;
  always_comb begin
    state_n = state;
    en      = 1'b0;
    sclr    = 1'b0;
    case (state)
      ST_IDLE: if (ld) begin
        state_n = ST_RUN;
        sclr    = 1'b1;
      end
      ST_RUN: if (abort) begin
        state_n = ST_IDLE;
        sclr    = 1'b1;
      end else if (pause) begin
        state_n = ST_PAUSE;
      end else begin
        en      = 1'b1;
        state_n = cnt_tc && last ? ST_DONE : ST_RUN;
      end
      ST_PAUSE: if (abort) begin
        state_n = ST_IDLE;
        sclr    = 1'b1;
      end else if (!pause) begin
        state_n = ST_RUN;
      end
      default: begin
        state_n = ST_IDLE;
        sclr    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state     <= ST_IDLE;
      periods_q <= '0;
      pcnt      <= '0;
    end else begin
      state <= state_n;
      if (ld) begin
        periods_q <= periods;
        pcnt      <= '0;
      end else if (en && cnt_tc) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  assign tc     = state == ST_RUN && cnt_tc;
  assign busy   = state == ST_RUN || state == ST_PAUSE;
  assign paused = state == ST_PAUSE;
  assign done   = state == ST_DONE;
`ifdef WRAP_COUNT_EN
  assign wrap_cnt = pcnt;
`else
  assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb_mod_counter_ctrl: scoreboard-driven directed bench for mod_counter_ctrl at MOD=12
module tb_mod_counter_ctrl;
  localparam int S_CNT = 0, S_BUSY = 1, S_PAUSED = 2, S_DONE = 3, S_TC = 4, S_WRAP = 5;
`ifdef WRAP_COUNT_EN
  localparam bit WON = 1'b1;
`else
  localparam bit WON = 1'b0;
`endif
  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic clr, start, pause, abort;
  logic [3:0] periods;
  logic [3:0] count;
  logic tc, busy, paused, done;
  logic [3:0] wrap_cnt;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  mod_counter_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .periods  (periods),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .paused   (paused),
    .done     (done),
    .wrap_cnt (wrap_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(int s);
    case (s)
      S_CNT:    obs = 32'(count);
      S_BUSY:   obs = 32'(busy);
      S_PAUSED: obs = 32'(paused);
      S_DONE:   obs = 32'(done);
      S_TC:     obs = 32'(tc);
      default:  obs = 32'(wrap_cnt);
    endcase
  endfunction
  function automatic void push(string tag, int s, int e);
    sb.push_back('{tag, s, 32'(e)});
  endfunction
  function automatic void exp_all(string tag, int c, int b, int p, int d, int t);
    push({tag, ".count"}, S_CNT, c);
    push({tag, ".busy"}, S_BUSY, b);
    push({tag, ".paused"}, S_PAUSED, p);
    push({tag, ".done"}, S_DONE, d);
    push({tag, ".tc"}, S_TC, t);
  endfunction
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs(e.sig) === e.exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs(e.sig), e.exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
    drain();
  endtask
  initial begin
    clr = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; periods = '0;
    #2;
    exp_all("rst", 0, 0, 0, 0, 0);
    push("rst.wrap", S_WRAP, 0);
    drain();
    #8 clr = 1'b0;
    repeat (3) begin
      exp_all("idle", 0, 0, 0, 0, 0);
      step();
    end
    periods = 4'd1; start = 1'b1;
    exp_all("os.start", 0, 1, 0, 0, 0);
    step();
    start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      exp_all($sformatf("os%0d", i), i, 1, 0, 0, int'(i == 11));
      step();
    end
    exp_all("os.done", 0, 0, 0, 1, 0);
    push("os.wrap", S_WRAP, WON ? 1 : 0);
    step();
    exp_all("os.after", 0, 0, 0, 0, 0);
    step();
    periods = 4'd2; start = 1'b1;
    push("os2.start", S_BUSY, 1);
    step();
    start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      push($sformatf("os2_%0d.count", i), S_CNT, i % 12);
      push($sformatf("os2_%0d.done", i), S_DONE, int'(i == 24));
      push($sformatf("os2_%0d.busy", i), S_BUSY, int'(i < 24));
      step();
    end
    push("os2.after.done", S_DONE, 0);
    step();
    periods = 4'd0; start = 1'b1;
    exp_all("ct.start", 0, 1, 0, 0, 0);
    step();
    start = 1'b0; periods = 4'd1;
    for (int i = 1; i <= 29; i++) begin
      start = i == 3;
      push($sformatf("ct%0d.count", i), S_CNT, i % 12);
      push($sformatf("ct%0d.done", i), S_DONE, 0);
      push($sformatf("ct%0d.busy", i), S_BUSY, 1);
      step();
    end
    start = 1'b0;
    push("ct.wrap", S_WRAP, WON ? 2 : 0);
    drain();
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_all($sformatf("pause%0d", k), 5, 1, 1, 0, 0);
      step();
    end
    pause = 1'b0;
    exp_all("resume.exit", 5, 1, 0, 0, 0);
    step();
    exp_all("resume.inc", 6, 1, 0, 0, 0);
    step();
    for (int i = 7; i <= 11; i++) begin
      push($sformatf("run%0d.count", i), S_CNT, i);
      push($sformatf("run%0d.tc", i), S_TC, int'(i == 11));
      step();
    end
    pause = 1'b1;
    exp_all("pause11", 11, 1, 1, 0, 0);
    step();
    pause = 1'b0;
    exp_all("resume11", 11, 1, 0, 0, 1);
    step();
    exp_all("wrap3", 0, 1, 0, 0, 0);
    push("wrap3.wrap", S_WRAP, WON ? 3 : 0);
    step();
    for (int i = 1; i <= 7; i++) begin
      push($sformatf("pre_abort%0d", i), S_CNT, i);
      step();
    end
    abort = 1'b1; pause = 1'b1;
    exp_all("abort", 0, 0, 0, 0, 0);
    step();
    abort = 1'b0; pause = 1'b0;
    exp_all("abort.idle", 0, 0, 0, 0, 0);
    step();
    periods = 4'd0; start = 1'b1;
    push("ar.start", S_BUSY, 1);
    step();
    start = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      push($sformatf("ar%0d", i), S_CNT, i % 12);
      step();
    end
    push("ar.wrap", S_WRAP, WON ? 1 : 0);
    drain();
    clr = 1'b1;
    #1;
    exp_all("ar.clr", 0, 0, 0, 0, 0);
    push("ar.clr.wrap", S_WRAP, 0);
    drain();
    #1 clr = 1'b0;
    exp_all("ar.idle", 0, 0, 0, 0, 0);
    step();
    start = 1'b1;
    exp_all("ar.restart", 0, 1, 0, 0, 0);
    step();
    start = 1'b0;
    exp_all("ar.run1", 1, 1, 0, 0, 0);
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
